// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks a single active-low row, samples the columns on a
// divided tick, and debounces both press and release of one key at a time.
//
// state         | meaning
// ST_SCAN       | advance row on each all-high tick, wait for any low column
// ST_PRESS_DB   | (row,col) latched, counting consecutive low samples of col
// ST_HELD       | key accepted, row frozen, other keys ignored
// ST_RELEASE_DB | counting consecutive all-high samples before rescanning
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_down
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_SCAN       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       col_s1, col_s2;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       row, col_sel, col_low_idx;
   logic             tick, all_high, sel_low, cnt_done;
   logic             accept, row_adv, cnt_inc;
   logic [3:0]       key_code;

   // col_n is asynchronous to clk; idle value of the synchronizer is "no key".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_s1 <= 4'hF;
         col_s2 <= 4'hF;
      end else begin
         col_s1 <= col_n;
         col_s2 <= col_s1;
      end
   end

   assign tick     = (div == DIV_LAST);
   assign all_high = (col_s2 == 4'hF);
   assign sel_low  = ~col_s2[col_sel];
   assign cnt_done = (cnt == CNT_DONE);

   always_comb begin
      col_low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!col_s2[i]) col_low_idx = 2'(i);
      end
   end

   always_comb begin
      case ({row, col_sel})
         4'h0:    key_code = 4'h1;
         4'h1:    key_code = 4'h2;
         4'h2:    key_code = 4'h3;
         4'h3:    key_code = 4'hA;
         4'h4:    key_code = 4'h4;
         4'h5:    key_code = 4'h5;
         4'h6:    key_code = 4'h6;
         4'h7:    key_code = 4'hB;
         4'h8:    key_code = 4'h7;
         4'h9:    key_code = 4'h8;
         4'hA:    key_code = 4'h9;
         4'hB:    key_code = 4'hC;
         4'hC:    key_code = 4'hE;
         4'hD:    key_code = 4'h0;
         4'hE:    key_code = 4'hF;
         default: key_code = 4'hD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_SCAN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_SCAN: begin
            if (tick && !all_high) state_nxt = ST_PRESS_DB;
         end
         ST_PRESS_DB: begin
            if (cnt_done)                 state_nxt = ST_HELD;
            else if (tick && !sel_low)    state_nxt = ST_SCAN;
         end
         ST_HELD: begin
            if (tick && all_high) state_nxt = ST_RELEASE_DB;
         end
         ST_RELEASE_DB: begin
            if (cnt_done)                 state_nxt = ST_SCAN;
            else if (tick && !all_high)   state_nxt = ST_HELD;
         end
         default: state_nxt = ST_SCAN;
      endcase
   end

   always_comb begin
      row_n    = ~(4'b0001 << row);
      key_down = (state == ST_HELD) || (state == ST_RELEASE_DB);
      accept   = (state == ST_PRESS_DB) && cnt_done;
      row_adv  = ((state == ST_SCAN) && tick && all_high) ||
                 ((state != ST_SCAN) && (state_nxt == ST_SCAN));
      cnt_inc  = tick && (((state == ST_PRESS_DB) && sel_low) ||
                          ((state == ST_RELEASE_DB) && all_high));
   end

   // The sample that causes a debounce state entry already counts as the first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div       <= '0;
         row       <= 2'd0;
         col_sel   <= 2'd0;
         cnt       <= '0;
         key       <= 4'h0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= accept;
         if (accept) key <= key_code;
         if (tick || row_adv) div <= '0;
         else                 div <= div + 1'b1;
         if (row_adv) row <= row + 2'd1;
         if ((state == ST_SCAN) && (state_nxt == ST_PRESS_DB)) col_sel <= col_low_idx;
         if (state_nxt != state)
            cnt <= ((state_nxt == ST_PRESS_DB) || (state_nxt == ST_RELEASE_DB)) ? CNT_W'(1) : '0;
         else if (cnt_inc && !cnt_done)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model pulls a column low only while
// its row is driven; expected keys and strobe counts come from the key table.
module tb_keypad_scanner;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key;
   logic       key_valid;
   logic       key_down;

   logic [3:0] pressed [4];
   logic [3:0] keymap [16];
   int         vectors = 0;
   int         miscompares = 0;
   int         strobe_cnt = 0;
   int         exp_strobes = 0;
   logic [3:0] exp_key = 4'h0;
   logic       prev_kv = 1'b0;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
      .key(key), .key_valid(key_valid), .key_down(key_down)
   );

   always #5 clk = ~clk;

   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r][c] && (row_n[r] == 1'b0)) col_n[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         strobe_cnt++;
         vectors++;
         if (prev_kv !== 1'b0) begin
            miscompares++;
            $display("FAIL strobe_consecutive: previous key_valid=%b, required 0", prev_kv);
         end
      end
      prev_kv = key_valid;
   end

   function automatic logic [3:0] row_code(input int r);
      logic [3:0] one;
      one = 4'b0001;
      return 4'b1111 ^ (one << r);
   endfunction

   task automatic release_all();
      for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
   endtask

   task automatic wait_strobe(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk); #1;
         if (key_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_keyup(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk); #1;
         if (key_down === 1'b0) ok = 1'b1;
      end
   endtask

   // Returns just after the edge on which row r becomes the driven row.
   task automatic wait_row_entry(input int r, output bit ok);
      bit left;
      left = (row_n !== row_code(r));
      ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(posedge clk); #1;
         if (row_n !== row_code(r)) left = 1'b1;
         else if (left) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      release_all();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (row_n !== 4'b1110) begin miscompares++; $display("FAIL reset_row_n: got %b, required 1110", row_n); end
      vectors++; if (key !== 4'h0) begin miscompares++; $display("FAIL reset_key: got %h, required 0", key); end
      vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid: got %b, required 0", key_valid); end
      vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL reset_key_down: got %b, required 0", key_down); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_idle_scan();
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         vectors++;
         if (row_n !== row_code((n / SCAN_DIV) % 4)) begin
            miscompares++;
            $display("FAIL idle_row_n clk %0d: got %b, required %b", n, row_n, row_code((n / SCAN_DIV) % 4));
         end
      end
      vectors++; if (strobe_cnt !== exp_strobes) begin miscompares++; $display("FAIL idle_strobes: got %0d, required %0d", strobe_cnt, exp_strobes); end
   endtask

   // Full press of one key with release; checks strobe, hold and release timing.
   task automatic press_full(input int r, input int c, input int hold, input string tag);
      bit ok;
      pressed[r][c] = 1'b1;
      wait_strobe(100, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL %s_strobe_timeout: key_valid not seen, required within 100 clocks", tag); end
      exp_key = keymap[r*4 + c];
      exp_strobes++;
      vectors++; if (key !== exp_key) begin miscompares++; $display("FAIL %s_key: got %h, required %h", tag, key, exp_key); end
      vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL %s_key_down_at_strobe: got %b, required 1", tag, key_down); end
      @(posedge clk); #1;
      vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL %s_strobe_width: got %b, required 0", tag, key_valid); end
      repeat (hold) @(posedge clk);
      #1;
      vectors++; if (strobe_cnt !== exp_strobes) begin miscompares++; $display("FAIL %s_held_strobes: got %0d, required %0d", tag, strobe_cnt, exp_strobes); end
      release_all();
      repeat (10) @(posedge clk);
      #1;
      vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL %s_release_early: key_down got %b, required 1", tag, key_down); end
      wait_keyup(20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL %s_keyup_timeout: key_down still high, required low within 20 clocks", tag); end
      vectors++; if (row_n !== row_code((r + 1) % 4)) begin miscompares++; $display("FAIL %s_rescan_row: got %b, required %b", tag, row_n, row_code((r + 1) % 4)); end
      vectors++; if (key !== exp_key) begin miscompares++; $display("FAIL %s_key_kept: got %h, required %h", tag, key, exp_key); end
   endtask

   // Press seen on k ticks (k < DEBOUNCE), then released: must be discarded.
   task automatic press_bounce(input int r, input int c, input int k, input string tag);
      bit ok;
      wait_row_entry(r, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL %s_row_timeout: row %0d not driven, required within 64 clocks", tag, r); end
      pressed[r][c] = 1'b1;
      repeat (SCAN_DIV * k) @(posedge clk);
      #1;
      release_all();
      vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL %s_key_down: got %b, required 0", tag, key_down); end
      repeat (SCAN_DIV) @(posedge clk);
      #1;
      vectors++; if (row_n !== row_code((r + 1) % 4)) begin miscompares++; $display("FAIL %s_resume_row: got %b, required %b", tag, row_n, row_code((r + 1) % 4)); end
      vectors++; if (strobe_cnt !== exp_strobes) begin miscompares++; $display("FAIL %s_strobes: got %0d, required %0d", tag, strobe_cnt, exp_strobes); end
      vectors++; if (key !== exp_key) begin miscompares++; $display("FAIL %s_key: got %h, required %h", tag, key, exp_key); end
   endtask

   task automatic test_press_hold();
      press_full(2, 1, 30, "hold_r2c1");
   endtask

   task automatic test_bounce();
      press_bounce(0, 3, 2, "bounce_r0c3");
   endtask

   task automatic test_held_ignore();
      bit ok;
      pressed[3][0] = 1'b1;
      wait_strobe(100, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL ignore_strobe_timeout: key_valid not seen, required within 100 clocks"); end
      exp_key = keymap[12];
      exp_strobes++;
      vectors++; if (key !== exp_key) begin miscompares++; $display("FAIL ignore_key: got %h, required %h", key, exp_key); end
      pressed[1][2] = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      vectors++; if (strobe_cnt !== exp_strobes) begin miscompares++; $display("FAIL ignore_second_key: strobes got %0d, required %0d", strobe_cnt, exp_strobes); end
      release_all();
      wait_keyup(30, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL ignore_keyup_timeout: key_down still high, required low within 30 clocks"); end
      repeat (40) @(posedge clk);
      #1;
      vectors++; if (strobe_cnt !== exp_strobes) begin miscompares++; $display("FAIL ignore_after_release: strobes got %0d, required %0d", strobe_cnt, exp_strobes); end
      vectors++; if (key !== exp_key) begin miscompares++; $display("FAIL ignore_key_kept: got %h, required %h", key, exp_key); end
   endtask

   task automatic test_lowest_col();
      bit ok;
      int low;
      pressed[1] = 4'b0101;
      low = 4;
      for (int c = 3; c >= 0; c--) if (pressed[1][c]) low = c;
      wait_strobe(100, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL lowcol_strobe_timeout: key_valid not seen, required within 100 clocks"); end
      exp_key = keymap[4 + low];
      exp_strobes++;
      vectors++; if (key !== exp_key) begin miscompares++; $display("FAIL lowcol_key: got %h, required %h", key, exp_key); end
      release_all();
      wait_keyup(30, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL lowcol_keyup_timeout: key_down still high, required low within 30 clocks"); end
   endtask

   task automatic test_reset_mid_debounce();
      bit ok;
      wait_row_entry(0, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rstdb_row_timeout: row 0 not driven, required within 64 clocks"); end
      pressed[0][2] = 1'b1;
      repeat (SCAN_DIV * 2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_key = 4'h0;
      #1;
      vectors++; if (row_n !== 4'b1110) begin miscompares++; $display("FAIL rstdb_row_n: got %b, required 1110", row_n); end
      vectors++; if (key !== exp_key) begin miscompares++; $display("FAIL rstdb_key: got %h, required %h", key, exp_key); end
      vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rstdb_key_valid: got %b, required 0", key_valid); end
      vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL rstdb_key_down: got %b, required 0", key_down); end
      repeat (3) @(posedge clk);
      release_all();
      @(negedge clk);
      reset = 1'b1;
      repeat (SCAN_DIV - 1) @(posedge clk);
      #1;
      vectors++; if (row_n !== row_code(0)) begin miscompares++; $display("FAIL rstdb_resume_row0: got %b, required %b", row_n, row_code(0)); end
      @(posedge clk); #1;
      vectors++; if (row_n !== row_code(1)) begin miscompares++; $display("FAIL rstdb_resume_row1: got %b, required %b", row_n, row_code(1)); end
      vectors++; if (strobe_cnt !== exp_strobes) begin miscompares++; $display("FAIL rstdb_strobes: got %0d, required %0d", strobe_cnt, exp_strobes); end
      press_full(0, 1, 8, "rstdb_fresh");
   endtask

   task automatic test_random();
      for (int n = 0; n < 14; n++) begin
         int r, c, mode;
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         mode = $urandom_range(0, 2);
         if (mode == 0)
            press_bounce(r, c, $urandom_range(1, DEBOUNCE - 1), "rand_bounce");
         else
            press_full(r, c, $urandom_range(5, 20), "rand_press");
      end
   endtask

   initial begin
      keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
                 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC,
                 4'hE, 4'h0, 4'hF, 4'hD};
      release_all();
      test_reset();
      test_idle_scan();
      test_press_hold();
      test_bounce();
      test_held_ignore();
      test_lowest_col();
      test_reset_mid_debounce();
      test_random();
      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
